// File: rtl/dl_fpu_issue_ctrl_if.sv
// Requester / FPU datapath / consumer signal bundle for dl_fpu_issue_ctrl.
interface dl_fpu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] in_op3;
    logic        fpu_start;
    logic [31:0] fpu_instr;
    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [31:0] fpu_op3;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_excep;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_excep;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        busy;

    // Issue controller side
    modport slave (
        input  in_valid, in_instr, in_op1, in_op2, in_op3,
        input  fpu_result, fpu_excep, out_ready, fflags_clr,
        output in_ready, fpu_start, fpu_instr, fpu_op1, fpu_op2, fpu_op3,
        output out_valid, out_result, out_excep, fflags, busy
    );

    // Requester / datapath / consumer side
    modport master (
        output in_valid, in_instr, in_op1, in_op2, in_op3,
        output fpu_result, fpu_excep, out_ready, fflags_clr,
        input  in_ready, fpu_start, fpu_instr, fpu_op1, fpu_op2, fpu_op3,
        input  out_valid, out_result, out_excep, fflags, busy
    );
endinterface

// File: rtl/dl_fpu_issue_ctrl.sv
// DLFloat FPU issue controller: instruction FIFO feeding a single-in-flight
// issue/wait/done sequencer with sticky exception flag accumulation.
module dl_fpu_issue_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LAT_BASE = 2,
    parameter int unsigned LAT_MAC  = 3,
    parameter int unsigned LAT_LONG = 5
) (
    input  logic               clk,
    input  logic               rst,
    dl_fpu_issue_ctrl_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W   = 128;
    localparam int unsigned LAT_MX1 = (LAT_MAC > LAT_BASE) ? LAT_MAC : LAT_BASE;
    localparam int unsigned LAT_MAX = (LAT_LONG > LAT_MX1) ? LAT_LONG : LAT_MX1;
    localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LAT_W-1:0]   wait_q, wait_d, lat_c;
    logic               fpu_start_q, fpu_start_d;
    logic [31:0]        instr_q, instr_d, op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_result_q, out_result_d;
    logic [4:0]         out_excep_q, out_excep_d;
    logic [4:0]         fflags_q, fflags_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               push_c, pop_c, capture_c;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    assign push_c = bus.in_valid && in_ready_q;

    // Queue storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {bus.in_instr, bus.in_op1, bus.in_op2, bus.in_op3};
        end
    end

    // Latency class of the instruction sitting in the issue registers
    always_comb begin
        lat_c = LAT_W'(LAT_BASE);
        if (instr_q[6:4] == 3'b100) begin
            lat_c = LAT_W'(LAT_MAC);
        end else if (instr_q[31:27] == 5'b00011 || instr_q[31:27] == 5'b01011) begin
            lat_c = LAT_W'(LAT_LONG);
        end
    end

    // Sequencer next state, queue bookkeeping and registered-output next values
    always_comb begin
        state_d      = state_q;
        pop_c        = 1'b0;
        capture_c    = 1'b0;
        wait_d       = wait_q;
        instr_d      = instr_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        op3_d        = op3_q;
        out_result_d = out_result_q;
        out_excep_d  = out_excep_q;
        fflags_d     = fflags_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = lat_c - LAT_W'(2);
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_c) begin
            {instr_d, op1_d, op2_d, op3_d} = mem_q[rd_ptr_q];
        end

        // New flags win over a coincident clear
        if (capture_c) begin
            out_result_d = bus.fpu_result;
            out_excep_d  = bus.fpu_excep;
            fflags_d     = bus.fflags_clr ? bus.fpu_excep : (fflags_q | bus.fpu_excep);
        end else if (bus.fflags_clr) begin
            fflags_d = '0;
        end

        wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        busy_d      = (state_d != IDLE) || (count_d != '0);
        fpu_start_d = (state_d == ISSUE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            fpu_start_q  <= 1'b0;
            instr_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            op3_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_excep_q  <= '0;
            fflags_q     <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            fpu_start_q  <= fpu_start_d;
            instr_q      <= instr_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op3_q        <= op3_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_excep_q  <= out_excep_d;
            fflags_q     <= fflags_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.fpu_start  = fpu_start_q;
    assign bus.fpu_instr  = instr_q;
    assign bus.fpu_op1    = op1_q;
    assign bus.fpu_op2    = op2_q;
    assign bus.fpu_op3    = op3_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_excep  = out_excep_q;
    assign bus.fflags     = fflags_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dl_fpu_issue_ctrl.sv
// Directed self-checking bench for dl_fpu_issue_ctrl with a result scoreboard.
module tb_dl_fpu_issue_ctrl;
    logic clk;
    logic rst;

    dl_fpu_issue_ctrl_if bus();

    dl_fpu_issue_ctrl #(
        .DEPTH(4), .LAT_BASE(2), .LAT_MAC(3), .LAT_LONG(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  exc;
        int          lat;
    } exp_t;

    localparam logic [31:0] I_ADD  = {5'b00000, 2'b00, 18'h0, 7'b1010011};
    localparam logic [31:0] I_MUL  = {5'b00010, 2'b00, 18'h0, 7'b1010011};
    localparam logic [31:0] I_DIV  = {5'b00011, 2'b00, 18'h0, 7'b1010011};
    localparam logic [31:0] I_SQRT = {5'b01011, 2'b00, 18'h0, 7'b1010011};
    localparam logic [31:0] I_MAC  = {5'b00100, 2'b00, 18'h0, 7'b1000011};

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    logic prev_ov   = 1'b0;

    // Stand-in FPU datapath: result and flags derived from the issued operands
    assign bus.fpu_result = bus.fpu_op1 + (bus.fpu_op2 ^ bus.fpu_op3);
    assign bus.fpu_excep  = bus.fpu_op3[31:27];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.res = a + (b ^ c);
        e.exc = c[31:27];
        if (instr[6:4] == 3'b100) e.lat = 3;
        else if (instr[31:27] == 5'b00011 || instr[31:27] == 5'b01011) e.lat = 5;
        else e.lat = 2;
        return e;
    endfunction

    function automatic logic [31:0] mk_op3(input logic [4:0] exc, input logic [26:0] low);
        return {exc, low};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for one cycle; it must be accepted
    task automatic push1(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_op1   = a;
        bus.in_op2   = b;
        bus.in_op3   = c;
        chk("push_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        sb.push_back(model(instr, a, b, c));
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string tag);
        for (int i = 0; i < 40 && !bus.out_valid; i++) step();
        chk(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 40 && !bus.fpu_start; i++) step();
        chk(tag, 32'(bus.fpu_start), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (bus.busy || sb.size() != 0); i++) step();
        chk(tag, 32'(sb.size()), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Latency and in-order result checking against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.fpu_start) start_cyc = cyc;
            if (bus.out_valid && !prev_ov) begin
                chk("out_valid_has_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("latency", 32'(cyc - start_cyc), 32'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_excep", 32'(bus.out_excep), 32'(e.exc));
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_exc;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_op1     = '0;
        bus.in_op2     = '0;
        bus.in_op3     = '0;
        bus.out_ready  = 1'b0;
        bus.fflags_clr = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_fpu_start", 32'(bus.fpu_start), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fflags", 32'(bus.fflags), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_fpu_instr", bus.fpu_instr, 32'd0);
        rst = 1'b0;
        step();

        // Single add: issue two cycles after push, result two cycles after issue
        bus.out_ready = 1'b1;
        push1(I_ADD, 32'h0000_0010, 32'h0000_0003, mk_op3(5'b00000, 27'h5));
        chk("add_c1_fpu_start", 32'(bus.fpu_start), 32'd0);
        chk("add_c1_busy", 32'(bus.busy), 32'd1);
        step();
        chk("add_c2_fpu_start", 32'(bus.fpu_start), 32'd1);
        chk("add_c2_fpu_instr", bus.fpu_instr, I_ADD);
        step();
        chk("add_c3_fpu_start", 32'(bus.fpu_start), 32'd0);
        chk("add_c3_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("add_c4_out_valid", 32'(bus.out_valid), 32'd1);
        chk("add_c4_out_result", bus.out_result, 32'h0000_0016);
        step();
        chk("add_c5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("add_c5_busy", 32'(bus.busy), 32'd0);

        // Divide with div-by-zero flag
        push1(I_DIV, 32'h1234_0000, 32'h0000_00ff, mk_op3(5'b01000, 27'h11));
        wait_ov("div_out_valid");
        chk("div_out_excep", 32'(bus.out_excep), 32'h08);
        chk("div_fflags", 32'(bus.fflags), 32'h08);
        step();
        drain("div_drain");

        // Five back-to-back pushes with consumer stalled
        bus.out_ready = 1'b0;
        push1(I_ADD,  32'h0000_0100, 32'h0000_0001, mk_op3(5'b00000, 27'h2));
        push1(I_MAC,  32'h0000_0200, 32'h0000_0010, mk_op3(5'b00000, 27'h3));
        push1(I_DIV,  32'h0000_0300, 32'h0000_0100, mk_op3(5'b00000, 27'h4));
        push1(I_SQRT, 32'h0000_0400, 32'h0000_1000, mk_op3(5'b00000, 27'h5));
        push1(I_MUL,  32'h0000_0500, 32'h0001_0000, mk_op3(5'b00000, 27'h6));
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        wait_ov("stall_out_valid");
        held_res = bus.out_result;
        held_exc = bus.out_excep;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_out_result", bus.out_result, held_res);
            chk("hold_out_excep", 32'(bus.out_excep), 32'(held_exc));
            chk("hold_fpu_start", 32'(bus.fpu_start), 32'd0);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("space_in_ready", 32'(bus.in_ready), 32'd1);
        drain("burst_drain");

        // Sticky flag accumulation and plain clear
        bus.fflags_clr = 1'b1;
        step();
        bus.fflags_clr = 1'b0;
        push1(I_ADD, 32'h1, 32'h2, mk_op3(5'b00001, 27'h7));
        wait_ov("fl1_out_valid");
        chk("fl1_fflags", 32'(bus.fflags), 32'h01);
        step();
        push1(I_ADD, 32'h3, 32'h4, mk_op3(5'b10000, 27'h8));
        wait_ov("fl2_out_valid");
        chk("fl2_fflags", 32'(bus.fflags), 32'h11);
        step();
        bus.fflags_clr = 1'b1;
        step();
        bus.fflags_clr = 1'b0;
        chk("clr_fflags", 32'(bus.fflags), 32'h00);

        // Clear coinciding with a capture: new flags win
        push1(I_ADD, 32'h5, 32'h6, mk_op3(5'b00001, 27'h9));
        wait_ov("fl3_out_valid");
        step();
        push1(I_ADD, 32'h7, 32'h8, mk_op3(5'b10000, 27'ha));
        wait_start("fl4_fpu_start");
        step();
        bus.fflags_clr = 1'b1;
        step();
        bus.fflags_clr = 1'b0;
        chk("clr_on_capture_fflags", 32'(bus.fflags), 32'h10);
        chk("clr_on_capture_ov", 32'(bus.out_valid), 32'd1);
        drain("fl_drain");

        // Asynchronous reset during a sqrt wait with three queued
        push1(I_SQRT, 32'h9, 32'ha, mk_op3(5'b00010, 27'hb));
        push1(I_ADD,  32'hb, 32'hc, mk_op3(5'b00000, 27'hc));
        push1(I_ADD,  32'hd, 32'he, mk_op3(5'b00000, 27'hd));
        push1(I_ADD,  32'hf, 32'h1, mk_op3(5'b00000, 27'he));
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_fflags", 32'(bus.fflags), 32'd0);
        chk("arst_out_result", bus.out_result, 32'd0);
        chk("arst_fpu_op1", bus.fpu_op1, 32'd0);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
